tmds_channel_decoder: RTL
=========================

TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

Interface
REQ-001 Parameter LOCK_COUNT, default 8, consecutive control tokens required to declare lock.
REQ-002 Parameter SEARCH_TIMEOUT, default 1024, cycles spent at one bit offset before advancing.
REQ-003 Parameter LOSS_TIMEOUT, default 65536, cycles without a control token before lock is dropped.
REQ-004 Port clk_in, input, 1, pixel clock; the single clock.
REQ-005 Port rst_in, input, 1, reset; synchronous, active-high.
REQ-006 Port tmds_in, input, 10, deserialized word, bit 0 received first, arbitrary bit alignment.
REQ-007 Port data_out, output, 8, decoded video byte.
REQ-008 Port ctrl_out, output, 2, decoded control bits {c1,c0}.
REQ-009 Port de_out, output, 1, 1 = data period, 0 = control period.
REQ-010 Port locked_out, output, 1, symbol alignment achieved.
REQ-011 Port offset_out, output, 4, current bit offset 0..9.

Function
REQ-012 Alignment: register previous word; form window {tmds_in, prev_word} of 20 bits; aligned symbol sym = window[offset +: 10].
REQ-013 Control tokens (sym[9:0]) decode as: 1101010100 -> 00, 0010101011 -> 01, 0101010100 -> 10, 1010101011 -> 11.
REQ-014 Control token present: de_out = 0, ctrl_out = token value, data_out holds its last value.
REQ-015 Otherwise: de_out = 1, ctrl_out holds its last value, data_out = decoded byte.
REQ-016 Data decode, step 1: if sym[9] = 1, q = ~sym[7:0], else q = sym[7:0].
REQ-017 Data decode, step 2: d[0] = q[0]; for i = 1..7, d[i] = q[i] ^ q[i-1] if sym[8] = 1, else d[i] = ~(q[i] ^ q[i-1]).
REQ-018 Pipeline: symbol is registered in stage 1 and outputs are registered in stage 2; latency is 2 clocks from the edge that samples the word completing the symbol.
REQ-019 Output behaviour during search: while locked_out = 0, outputs still update, and de_out, data_out and ctrl_out carry no guarantee.
REQ-020 FSM SEARCH, counters: tok_cnt counts consecutive control tokens at the current offset and clears on any non-token; dwell_cnt counts cycles at the current offset.
REQ-021 SEARCH -> LOCKED when tok_cnt reaches LOCK_COUNT; locked_out rises on the following edge.
REQ-022 SEARCH offset advance: when dwell_cnt reaches SEARCH_TIMEOUT-1 without lock, offset advances modulo 10 (9 wraps to 0) and both counters clear.
REQ-023 Simultaneous lock and timeout in the same cycle: lock wins and offset is unchanged.
REQ-024 FSM LOCKED: offset is frozen; quiet_cnt clears on every control token and increments otherwise.
REQ-025 LOCKED -> SEARCH when quiet_cnt reaches LOSS_TIMEOUT-1: locked_out falls, offset is kept, and tok_cnt and dwell_cnt clear.
REQ-026 Counter width: all counters are sized by $clog2 of their threshold plus 1 and saturate, never wrap.

Reset
REQ-027 While rst_in is high at an edge: FSM enters SEARCH; offset, all counters and prev_word clear to 0; all pipeline registers clear.
REQ-028 Output reset values: data_out = 0, ctrl_out = 0, de_out = 0, locked_out = 0, offset_out = 0.
REQ-029 Reset asserted mid-lock takes effect on that edge with no delayed outputs from older symbols.
REQ-030 Recovery: after rst_in deasserts, the first symbol decode appears 2 clocks later.

Structure
REQ-031 Shared package tmds_pkg holds the four control-token constants and the FSM state enum (SEARCH, LOCKED).
REQ-032 The encoder-side block reuses the tmds_pkg token constants.
REQ-033 One combinational sub-module, tm_decode, implements REQ-016 and REQ-017 (10-bit in, 8-bit out).
REQ-034 Alignment, FSM and output registers live in tmds_channel_decoder.

Verification
REQ-035 Aligned control stream, offset 0: 8 repetitions of 1101010100 -> locked_out = 1 on the edge after the 8th, offset_out = 0, de_out = 0, ctrl_out = 00.
REQ-036 Misaligned stream, shifted by 3 bits, control token 01 repeated -> offset_out steps every 1024 cycles, reaches 3, locks, and ctrl_out = 01.
REQ-037 After lock, full encoder output for bytes 0x00, 0xFF, 0x55 and 0xA5 with both sym[9] polarities -> data_out matches each byte 2 clocks later with de_out = 1.
REQ-038 After lock, 65536 data-only symbols -> locked_out falls and offset_out is retained; one control token at cycle 65535 prevents the drop.
REQ-039 rst_in for one cycle while locked mid-data -> all outputs 0 on that edge, FSM in SEARCH, relock after 8 tokens.
REQ-040 Boundary case: offset at 9 with timeout -> wraps to 0; a token run completing lock on the timeout cycle -> locks at the current offset with no advance.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token codes, alignment FSM states and token lookup.
package tmds_pkg;

    localparam logic [9:0] CTRL_TOK_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_TOK_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOK_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOK_11 = 10'b1010101011;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } tmds_state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] ctrl;
    } tok_t;

    function automatic tok_t tok_decode(input logic [9:0] sym);
        tok_t t;
        t.hit  = 1'b1;
        t.ctrl = 2'b00;
        case (sym)
            CTRL_TOK_00: t.ctrl = 2'b00;
            CTRL_TOK_01: t.ctrl = 2'b01;
            CTRL_TOK_10: t.ctrl = 2'b10;
            CTRL_TOK_11: t.ctrl = 2'b11;
            default:     t.hit  = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tm_decode.sv
// Combinational TMDS data-symbol decode: undo the optional inversion, then the XOR/XNOR chain.
module tm_decode (
    input  logic [9:0] sym,
    output logic [7:0] data
);

    logic [7:0] q;
    logic [7:0] chain;

    assign q     = sym[9] ? ~sym[7:0] : sym[7:0];
    assign chain = q ^ {q[6:0], 1'b0};
    // bit 0 passes straight through; sym[8] selects XOR (1) or XNOR (0) for the rest
    assign data  = sym[8] ? {chain[7:1], q[0]} : {~chain[7:1], q[0]};

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel: bit-offset search against control tokens, lock supervision and a two-stage decode pipeline.
//
//   state  | meaning
//   SEARCH | hunting for LOCK_COUNT consecutive tokens, stepping the offset on dwell timeout
//   LOCKED | offset frozen; drop back to SEARCH after LOSS_TIMEOUT cycles with no token
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT     = 8,
    parameter int SEARCH_TIMEOUT = 1024,
    parameter int LOSS_TIMEOUT   = 65536
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] tmds_in,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de_out,
    output logic       locked_out,
    output logic [3:0] offset_out
);

    localparam int TOK_W   = $clog2(LOCK_COUNT) + 1;
    localparam int DWELL_W = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int QUIET_W = $clog2(LOSS_TIMEOUT) + 1;

    localparam logic [TOK_W-1:0]   TOK_MAX    = TOK_W'(LOCK_COUNT);
    localparam logic [TOK_W-1:0]   TOK_LAST   = TOK_W'(LOCK_COUNT - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SEARCH_TIMEOUT - 1);
    localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(LOSS_TIMEOUT - 1);

    tmds_state_t        state;
    logic [9:0]         prev_word;
    logic [9:0]         sym_r;
    logic [TOK_W-1:0]   tok_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [QUIET_W-1:0] quiet_cnt;

    logic [18:0] window;
    logic [9:0]  sym;
    tok_t        tok_s;
    tok_t        tok_r;
    logic [7:0]  dec_byte;

    // tmds_in[9] can never fall inside a 10-bit window starting at offset <= 9
    assign window = {tmds_in[8:0], prev_word};

    always_comb begin
        sym = window[9:0];
        for (int k = 1; k < 10; k++) begin
            if (offset_out == 4'(k)) sym = window[k +: 10];
        end
    end

    assign tok_s = tok_decode(sym);
    assign tok_r = tok_decode(sym_r);

    tm_decode u_tm_decode (
        .sym  (sym_r),
        .data (dec_byte)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= SEARCH;
            prev_word  <= '0;
            sym_r      <= '0;
            tok_cnt    <= '0;
            dwell_cnt  <= '0;
            quiet_cnt  <= '0;
            offset_out <= '0;
            locked_out <= 1'b0;
            data_out   <= '0;
            ctrl_out   <= '0;
            de_out     <= 1'b0;
        end else begin
            prev_word <= tmds_in;
            sym_r     <= sym;

            if (tok_r.hit) begin
                de_out   <= 1'b0;
                ctrl_out <= tok_r.ctrl;
            end else begin
                de_out   <= 1'b1;
                data_out <= dec_byte;
            end

            case (state)
                SEARCH: begin
                    // lock is tested first so a run finishing on the timeout cycle keeps its offset
                    if (tok_s.hit && tok_cnt == TOK_LAST) begin
                        state      <= LOCKED;
                        locked_out <= 1'b1;
                        tok_cnt    <= TOK_MAX;
                        quiet_cnt  <= '0;
                    end else if (dwell_cnt == DWELL_LAST) begin
                        offset_out <= (offset_out == 4'd9) ? 4'd0 : offset_out + 4'd1;
                        tok_cnt    <= '0;
                        dwell_cnt  <= '0;
                    end else begin
                        if (!tok_s.hit)
                            tok_cnt <= '0;
                        else if (tok_cnt != TOK_MAX)
                            tok_cnt <= tok_cnt + 1'b1;
                        if (dwell_cnt != DWELL_LAST)
                            dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (quiet_cnt == QUIET_LAST) begin
                        state      <= SEARCH;
                        locked_out <= 1'b0;
                        tok_cnt    <= '0;
                        dwell_cnt  <= '0;
                        quiet_cnt  <= '0;
                    end else if (tok_s.hit) begin
                        quiet_cnt <= '0;
                    end else begin
                        quiet_cnt <= quiet_cnt + 1'b1;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule
